// File: rtl/start_ready_ctrl_pkg.sv
// Shared types and defaults for the start/ready handshake controller.
// Holds the controller state encoding, default sizing and the counter-width helper.
package start_ready_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RDY,
        PROC,
        RESP
    } state_t;

    localparam int DEF_DATA_W        = 3;
    localparam int DEF_START_LAT     = 3;
    localparam int DEF_OP_CYCLES     = 2;
    localparam int DEF_READY_TIMEOUT = 8;

    // One counter is shared by the wait, processing and ready-timeout phases.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEF_START_LAT, DEF_OP_CYCLES, DEF_READY_TIMEOUT);

endpackage

// File: rtl/start_ready_ctrl_if.sv
// Handshake bundle between the upstream driver (master) and start_ready_ctrl (slave).
interface start_ready_ctrl_if import start_ready_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
);

    logic              start;
    logic              enable;
    logic              valid;
    logic [DATA_W-1:0] data_in;
    logic              write;
    logic              lock;
    logic              unlock;
    logic              ready;
    logic              ack;
    logic [DATA_W-1:0] data_out;
    logic              d_valid;
    logic              done;
    logic              error;
    logic              busy;

    modport master (
        output start, enable, valid, data_in, write, lock, unlock,
        input  ready, ack, data_out, d_valid, done, error, busy
    );

    modport slave (
        input  start, enable, valid, data_in, write, lock, unlock,
        output ready, ack, data_out, d_valid, done, error, busy
    );

endinterface

// File: rtl/start_ready_ctrl_rise_detect.sv
// Registered rising-edge detector: rise is high while sig is 1 and was 0 at the previous edge.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sig_q <= 1'b0;
        else     sig_q <= sig;
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/start_ready_ctrl.sv
// Start/ready/ack/done transaction controller with lock/error status.
// Optional ready timeout is enabled by defining START_READY_TIMEOUT_EN.
module start_ready_ctrl import start_ready_pkg::*; #(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int START_LAT     = DEF_START_LAT,
    parameter int OP_CYCLES     = DEF_OP_CYCLES,
    parameter int READY_TIMEOUT = DEF_READY_TIMEOUT
) (
    input logic               clk,
    input logic               rst,
    start_ready_ctrl_if.slave bus
);

    localparam int CW = cnt_width(START_LAT, OP_CYCLES, READY_TIMEOUT);
    localparam logic [CW-1:0] WAIT_LAST = CW'(START_LAT - 2);
    localparam logic [CW-1:0] PROC_LAST = CW'(OP_CYCLES - 1);
`ifdef START_READY_TIMEOUT_EN
    localparam logic [CW-1:0] RDY_LAST  = CW'(READY_TIMEOUT - 1);
`endif

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              lock_r;
    logic [DATA_W-1:0] cap_data;
    logic              cap_write;
    logic [DATA_W-1:0] stored;
    logic              rise;
    logic              xfer;
    logic              lock_clash;
    logic              start_err;
    logic              timeout;

    rise_detect u_start_rise (
        .clk  (clk),
        .rst  (rst),
        .sig  (bus.start),
        .rise (rise)
    );

    // A rise while busy or locked is rejected; all error sources merge into one pulse.
    always_comb begin
        xfer       = (state == RDY) & bus.valid & bus.ready;
        lock_clash = bus.lock & bus.unlock;
        start_err  = rise & ((state != IDLE) | lock_r);
`ifdef START_READY_TIMEOUT_EN
        timeout    = (state == RDY) & ~xfer & (cnt == RDY_LAST);
`else
        timeout    = 1'b0;
`endif
    end

    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            lock_r       <= 1'b0;
            cap_data     <= '0;
            cap_write    <= 1'b0;
            stored       <= '0;
            bus.ready    <= 1'b0;
            bus.ack      <= 1'b0;
            bus.data_out <= '0;
            bus.d_valid  <= 1'b0;
            bus.done     <= 1'b0;
            bus.error    <= 1'b0;
        end else begin
            bus.ack     <= 1'b0;
            bus.d_valid <= 1'b0;
            bus.done    <= 1'b0;
            bus.error   <= start_err | lock_clash | timeout;

            if (bus.lock & ~bus.unlock)      lock_r <= 1'b1;
            else if (bus.unlock & ~bus.lock) lock_r <= 1'b0;

            case (state)
                IDLE: begin
                    if (rise & ~lock_r) begin
                        state <= WAIT;
                        cnt   <= '0;
                    end
                end
                // Ready is raised on the edge that ends the wait, so it lands START_LAT edges after the rise.
                WAIT: begin
                    if (bus.enable) begin
                        if (cnt == WAIT_LAST) begin
                            state     <= RDY;
                            cnt       <= '0;
                            bus.ready <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                RDY: begin
                    if (xfer) begin
                        cap_data  <= bus.data_in;
                        cap_write <= bus.write;
                        bus.ready <= 1'b0;
                        bus.ack   <= 1'b1;
                        state     <= PROC;
                        cnt       <= '0;
                    end
`ifdef START_READY_TIMEOUT_EN
                    else if (timeout) begin
                        bus.ready <= 1'b0;
                        state     <= IDLE;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
`endif
                end
                // The result is registered on entry to RESP so d_valid/done coincide with that state.
                PROC: begin
                    if (bus.enable) begin
                        if (cnt == PROC_LAST) begin
                            state       <= RESP;
                            cnt         <= '0;
                            bus.d_valid <= 1'b1;
                            bus.done    <= 1'b1;
                            if (cap_write) begin
                                bus.data_out <= cap_data + DATA_W'(1);
                                stored       <= cap_data;
                            end else begin
                                bus.data_out <= stored;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_start_ready_ctrl.sv
// Self-checking bench for start_ready_ctrl: phase-level reference model plus directed sequences.
module tb_start_ready_ctrl;

    localparam int DATA_W        = 3;
    localparam int START_LAT     = 3;
    localparam int OP_CYCLES     = 2;
    localparam int READY_TIMEOUT = 8;

    localparam int M_IDLE   = 0;
    localparam int M_WAIT   = 1;
    localparam int M_READY  = 2;
    localparam int M_PROC   = 3;
    localparam int M_RESULT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   passed = 0;
    bit   check_en = 1'b0;

    start_ready_ctrl_if #(.DATA_W(DATA_W)) bus ();

    start_ready_ctrl #(
        .DATA_W        (DATA_W),
        .START_LAT     (START_LAT),
        .OP_CYCLES     (OP_CYCLES),
        .READY_TIMEOUT (READY_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: phases with edges-remaining countdowns, arithmetic result.
    int m_phase, m_left, m_age, m_cap, m_stored, e_data;
    bit m_prev, m_lock, m_wr, m_rise, e_ack, e_dv, e_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = M_IDLE; m_left = 0; m_age = 0; m_cap = 0; m_stored = 0;
            m_prev = 0; m_lock = 0; m_wr = 0; e_ack = 0; e_dv = 0; e_err = 0; e_data = 0;
        end else begin
            m_rise = bus.start && !m_prev;
            m_prev = bus.start;
            e_ack  = 0;
            e_dv   = 0;
            e_err  = bus.lock && bus.unlock;
            if (m_rise && (m_phase != M_IDLE || m_lock)) e_err = 1;
            case (m_phase)
                M_IDLE: begin
                    if (m_rise && !m_lock) begin m_phase = M_WAIT; m_left = START_LAT - 1; end
                end
                M_WAIT: begin
                    if (bus.enable) begin
                        m_left--;
                        if (m_left == 0) begin m_phase = M_READY; m_age = 0; end
                    end
                end
                M_READY: begin
                    if (bus.valid) begin
                        m_cap = int'(bus.data_in); m_wr = bus.write; e_ack = 1;
                        m_phase = M_PROC; m_left = OP_CYCLES;
                    end
`ifdef START_READY_TIMEOUT_EN
                    else begin
                        m_age++;
                        if (m_age == READY_TIMEOUT) begin m_phase = M_IDLE; e_err = 1; end
                    end
`endif
                end
                M_PROC: begin
                    if (bus.enable) begin
                        m_left--;
                        if (m_left == 0) begin
                            if (m_wr) begin e_data = (m_cap + 1) % (1 << DATA_W); m_stored = m_cap; end
                            else e_data = m_stored;
                            e_dv = 1;
                            m_phase = M_RESULT;
                        end
                    end
                end
                default: m_phase = M_IDLE;
            endcase
            if (bus.lock && !bus.unlock) m_lock = 1;
            else if (bus.unlock && !bus.lock) m_lock = 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("ready",    32'(bus.ready),    32'(m_phase == M_READY));
            checkOutput("ack",      32'(bus.ack),      32'(e_ack));
            checkOutput("data_out", 32'(bus.data_out), e_data);
            checkOutput("d_valid",  32'(bus.d_valid),  32'(e_dv));
            checkOutput("done",     32'(bus.done),     32'(e_dv));
            checkOutput("error",    32'(bus.error),    32'(e_err));
            checkOutput("busy",     32'(bus.busy),     32'(m_phase != M_IDLE));
        end
    end

    task automatic applyStimulus(input logic s, input logic en, input logic v,
                                 input logic [DATA_W-1:0] d, input logic w,
                                 input logic lk, input logic ul);
        bus.start = s; bus.enable = en; bus.valid = v; bus.data_in = d;
        bus.write = w; bus.lock = lk; bus.unlock = ul;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input logic s);
        applyStimulus(s, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (bus.ready !== 1'b1 && n < 20) begin idle(1'b0); n++; end
        checkOutput({tag, "_ready"}, 32'(bus.ready), 32'd1);
    endtask

    task automatic run_op(input logic [DATA_W-1:0] d, input logic w,
                          input logic [DATA_W-1:0] exp_d, input bit stall, input string tag);
        int n;
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        wait_ready(tag);
        applyStimulus(1'b0, 1'b1, 1'b1, d, w, 1'b0, 1'b0);
        checkOutput({tag, "_ack"}, 32'(bus.ack), 32'd1);
        n = 0;
        while (bus.d_valid !== 1'b1 && n < 20) begin
            applyStimulus(1'b0, !(stall && n == 0), 1'b0, '0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        checkOutput({tag, "_dvalid"}, 32'(bus.d_valid), 32'd1);
        checkOutput({tag, "_data"}, 32'(bus.data_out), 32'(exp_d));
        idle(1'b0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.start = 0; bus.enable = 1; bus.valid = 0; bus.data_in = '0;
        bus.write = 0; bus.lock = 0; bus.unlock = 0;
        #1 rst = 1'b1;
        check_en = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_ready",    32'(bus.ready),    32'd0);
        checkOutput("rst_ack",      32'(bus.ack),      32'd0);
        checkOutput("rst_busy",     32'(bus.busy),     32'd0);
        checkOutput("rst_data_out", 32'(bus.data_out), 32'd0);
        checkOutput("rst_done",     32'(bus.done),     32'd0);
        checkOutput("rst_error",    32'(bus.error),    32'd0);
        rst = 1'b0;

        // Test 1: start latency
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        checkOutput("t1_busy_n",   32'(bus.busy),  32'd1);
        checkOutput("t1_ready_n",  32'(bus.ready), 32'd0);
        idle(1'b1);
        checkOutput("t1_ready_n1", 32'(bus.ready), 32'd0);
        idle(1'b1);
        checkOutput("t1_ready_n2", 32'(bus.ready), 32'd1);

        // Test 2: write 5 -> 6, then read back 5 with a PROC stall
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
        checkOutput("t2_ack",      32'(bus.ack),      32'd1);
        checkOutput("t2_ready_lo", 32'(bus.ready),    32'd0);
        idle(1'b0);
        checkOutput("t2_ack_lo",   32'(bus.ack),      32'd0);
        checkOutput("t2_dv_early", 32'(bus.d_valid),  32'd0);
        idle(1'b0);
        checkOutput("t2_dv",       32'(bus.d_valid),  32'd1);
        checkOutput("t2_done",     32'(bus.done),     32'd1);
        checkOutput("t2_data",     32'(bus.data_out), 32'd6);
        idle(1'b0);
        checkOutput("t2_dv_lo",    32'(bus.d_valid),  32'd0);
        checkOutput("t2_data_hold",32'(bus.data_out), 32'd6);
        checkOutput("t2_busy_lo",  32'(bus.busy),     32'd0);
        run_op(3'd2, 1'b0, 3'd5, 1'b1, "t2_read");

        // Test 3: wrap
        run_op(3'd7, 1'b1, 3'd0, 1'b0, "t3_wrap");

        // Test 4: rise during PROC, lock, clash
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        wait_ready("t4_proc");
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
        checkOutput("t4_ack",      32'(bus.ack),      32'd1);
        idle(1'b1);
        checkOutput("t4_busy_err", 32'(bus.error),    32'd1);
        idle(1'b1);
        checkOutput("t4_dv",       32'(bus.d_valid),  32'd1);
        checkOutput("t4_data",     32'(bus.data_out), 32'd3);
        checkOutput("t4_err_lo",   32'(bus.error),    32'd0);
        idle(1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("t4_lock_noerr", 32'(bus.error),  32'd0);
        idle(1'b1);
        checkOutput("t4_lock_err", 32'(bus.error),    32'd1);
        checkOutput("t4_lock_busy",32'(bus.busy),     32'd0);
        idle(1'b1);
        checkOutput("t4_lock_rdy", 32'(bus.ready),    32'd0);
        idle(1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        run_op(3'd4, 1'b1, 3'd5, 1'b0, "t4_unlock");
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        checkOutput("t4_clash_err", 32'(bus.error),   32'd1);
        idle(1'b0);
        run_op(3'd6, 1'b0, 3'd4, 1'b0, "t4_clash_read");
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
        checkOutput("t4_valid_idle_err", 32'(bus.error), 32'd0);
        checkOutput("t4_valid_idle_ack", 32'(bus.ack),   32'd0);

        // Test 5: WAIT stall, then reset during PROC
        idle(1'b0);
        idle(1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("t5_ready_n3", 32'(bus.ready), 32'd0);
        idle(1'b0);
        checkOutput("t5_ready_n4", 32'(bus.ready), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        checkOutput("t5_ack",      32'(bus.ack),   32'd1);
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_ack",  32'(bus.ack),   32'd0);
        checkOutput("t5_rst_busy", 32'(bus.busy),  32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            checkOutput("t5_no_done", 32'(bus.done), 32'd0);
        end

`ifdef START_READY_TIMEOUT_EN
        // Test 6: ready timeout
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);
        checkOutput("t6_ready", 32'(bus.ready), 32'd1);
        for (int i = 1; i < READY_TIMEOUT; i++) begin
            idle(1'b0);
            checkOutput("t6_hold", 32'(bus.ready), 32'd1);
        end
        idle(1'b0);
        checkOutput("t6_ready_lo", 32'(bus.ready), 32'd0);
        checkOutput("t6_err",      32'(bus.error), 32'd1);
        checkOutput("t6_busy_lo",  32'(bus.busy),  32'd0);
        idle(1'b0);
        checkOutput("t6_err_lo",   32'(bus.error), 32'd0);
`endif

        idle(1'b0);
        check_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
